// File: rtl/bloonstd1_soc_key_irq_pio_pkg.sv
// bloonstd1_pio_pkg: register map and edge-type constants shared by the PIO blocks
package bloonstd1_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/bloonstd1_soc_key_irq_pio_if.sv
// bloonstd1_soc_key_irq_pio_if: Avalon-MM slave bus of the key PIO
interface bloonstd1_soc_key_irq_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/bloonstd1_soc_key_irq_pio_debounce.sv
// bloonstd1_key_debounce: 2-FF synchroniser plus counter debouncer for one key
module bloonstd1_key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, accept;
  logic [CW-1:0] cnt;
  // Pulses are combinational so edge capture lands on the same edge stable flips
  assign accept = (s2 != stable) && (cnt == LAST);
  assign rise = accept && s2;
  assign fall = accept && !s2;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
      stable <= RESET_LEVEL;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == stable) cnt <= '0;
      else if (accept) begin
        stable <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bloonstd1_soc_key_irq_pio.sv
// bloonstd1_soc_key_irq_pio: debounced key input PIO with edge capture and maskable irq
module bloonstd1_soc_key_irq_pio
  import bloonstd1_pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bloonstd1_soc_key_irq_pio_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);
  logic [WIDTH-1:0] stable, rise, fall, hit, irqmask, edgecap, wd, clr;
  logic [31:0] rdata;
  logic wr;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    bloonstd1_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL(RESET_LEVEL[i])
    ) u_db (
      .clk(clk),
      .reset_n(reset_n),
      .key(in_port[i]),
      .stable(stable[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  if (WIDTH < 32) begin : g_pad
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:WIDTH];
  end
  assign wr = bus.chipselect && !bus.write_n;
  assign wd = bus.writedata[WIDTH-1:0];
  assign irq = |(edgecap & irqmask);
  always_comb begin
    hit = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
    clr = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;
    rdata = bus.address == ADDR_DATA    ? 32'(stable)  :
            bus.address == ADDR_IRQMASK ? 32'(irqmask) :
            bus.address == ADDR_EDGECAP ? 32'(edgecap) : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
      bus.readdata <= '0;
    end else begin
      if (wr && bus.address == ADDR_IRQMASK) irqmask <= wd;
      edgecap <= (edgecap & ~clr) | hit;
      bus.readdata <= rdata;
    end
  end
endmodule

// File: tb/tb_bloonstd1_soc_key_irq_pio.sv
// tb_bloonstd1_soc_key_irq_pio: directed checks of debounce, edge capture and irq
module tb_bloonstd1_soc_key_irq_pio;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] in_port;
  logic irq;
  logic [31:0] d;
  int n_cmp = 0;
  int n_bad = 0;
  bloonstd1_soc_key_irq_pio_if bus ();
  bloonstd1_soc_key_irq_pio #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1),
    .RESET_LEVEL(2'b11)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .in_port(in_port),
    .irq(irq)
  );
  always #5 clk = ~clk;

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b1;
    @(negedge clk);
    v = bus.readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.writedata = v;
    @(negedge clk);
    bus.write_n = 1'b1;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got %h want %h", bus.readdata, 32'h0); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    in_port = 2'b11;
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h3) begin n_bad++; $display("FAIL reset_level got %h want %h", d, 32'h3); end
  endtask

  task automatic test_bounce;
    in_port[0] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rd(2'd0, d);
      n_cmp++;
      if (d !== 32'h3 || irq !== 1'b0) begin n_bad++; $display("FAIL bounce_level[%0d] got %h/%b want 3/0", k, d, irq); end
    end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL bounce_edgecap got %h want 0", d); end
  endtask

  task automatic test_press;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      rd(2'd0, d);
      n_cmp++;
      if (d !== (k < 7 ? 32'h3 : 32'h2)) begin n_bad++; $display("FAIL press_latency[%0d] got %h want %h", k, d, k < 7 ? 32'h3 : 32'h2); end
    end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL press_edgecap got %h want 1", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL press_irq_masked got %b want 0", irq); end
  endtask

  task automatic test_irq;
    wr(2'd2, 32'h3);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_unmask got %b want 1", irq); end
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'h3) begin n_bad++; $display("FAIL irqmask_rd got %h want 3", d); end
    wr(2'd3, 32'h1);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c got %b want 0", irq); end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL edgecap_w1c got %h want 0", d); end
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reserved_rd got %h want 0", d); end
    wr(2'd0, 32'h0);
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL data_ro got %h want 2", d); end
  endtask

  task automatic test_set_wins;
    in_port[1] = 1'b0;
    repeat (5) @(negedge clk);
    wr(2'd3, 32'h2);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL setwin_irq got %b want 1", irq); end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL setwin_edgecap got %h want 2", d); end
    rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL setwin_level got %h want 0", d); end
  endtask

  task automatic test_reset_mid;
    in_port = 2'b11;
    repeat (10) @(negedge clk);
    in_port[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if (irq !== 1'b0 || bus.readdata !== 32'h0) begin n_bad++; $display("FAIL midreset_out got %b/%h want 0/0", irq, bus.readdata); end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_edgecap got %h want 0", d); end
    for (int k = 2; k <= 7; k++) begin
      rd(2'd0, d);
      n_cmp++;
      if (d !== (k < 7 ? 32'h3 : 32'h2)) begin n_bad++; $display("FAIL midreset_redebounce[%0d] got %h want %h", k, d, k < 7 ? 32'h3 : 32'h2); end
    end
    rd(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_irqmask got %h want 0", d); end
    rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL midreset_newedge got %h want 1", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got %b want 0", irq); end
  endtask

  initial begin
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'h0;
    test_reset();
    test_bounce();
    test_press();
    test_irq();
    test_set_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
